// File: rtl/spin_payout_pkg.sv
// Shared types for the spin payout block: FSM state encoding and win classes.
// The numeric win-class values are visible on the win_class output.
package spin_payout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_EVAL,
    ST_PAY,
    ST_DONE
  } spin_state_t;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'd0,
    WIN_PAIR   = 2'd1,
    WIN_RUN    = 2'd2,
    WIN_TRIPLE = 2'd3
  } win_class_t;

endpackage

// File: rtl/spin_payout_if.sv
// Bet/spin handshake plus balance and result signals between the slot-machine
// control (master) and the spin payout block (slave).
interface spin_payout_if #(
  parameter int CREDIT_W = 10,
  parameter int BET_W    = 4
);
  logic                bet_req;
  logic [BET_W-1:0]    bet_amount;
  logic                spin_valid;
  logic [11:0]         player_spin;
  logic [CREDIT_W-1:0] credits;
  logic [CREDIT_W-1:0] last_payout;
  logic [1:0]          win_class;
  logic                armed;
  logic                busy;
  logic                result_valid;
  logic                bet_reject;

  modport master (
    output bet_req, bet_amount, spin_valid, player_spin,
    input  credits, last_payout, win_class, armed, busy, result_valid, bet_reject
  );

  modport slave (
    input  bet_req, bet_amount, spin_valid, player_spin,
    output credits, last_payout, win_class, armed, busy, result_valid, bet_reject
  );
endinterface

// File: rtl/spin_payout_classifier.sv
// Combinational reel classifier: reel 1 in [11:8], reel 3 in [3:0].
// Priority is triple > run > pair > none; runs never wrap from F back to 0.
module spin_payout_classifier
  import spin_payout_pkg::*;
(
  input  logic [11:0] digits,
  output win_class_t  win_class
);
  logic [3:0] d1, d2, d3;

  assign d1 = digits[11:8];
  assign d2 = digits[7:4];
  assign d3 = digits[3:0];

  // Restricting d1 to D or below keeps d1+1 and d2+1 from wrapping
  always_comb begin
    win_class = WIN_NONE;
    if (d1 == d2 && d2 == d3)
      win_class = WIN_TRIPLE;
    else if (d1 <= 4'hD && d2 == d1 + 4'd1 && d3 == d2 + 4'd1)
      win_class = WIN_RUN;
    else if (d1 == d2 || d2 == d3 || d1 == d3)
      win_class = WIN_PAIR;
  end
endmodule

// File: rtl/spin_payout.sv
// Spin payout: charges a bet, classifies the next spin and credits the payout
// to the balance one credit per clock, saturating at the top of the range.
module spin_payout
  import spin_payout_pkg::*;
#(
  parameter int CREDIT_W      = 10,
  parameter int START_CREDITS = 100,
  parameter int BET_W         = 4,
  parameter int MULT_PAIR     = 2,
  parameter int MULT_RUN      = 5,
  parameter int MULT_TRIPLE   = 10
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  spin_payout_if.slave  bus
);
  localparam int CMP_W  = CREDIT_W + BET_W;
  localparam int PROD_W = CREDIT_W + BET_W + 8;

  spin_state_t         state, next_state;
  logic [CREDIT_W-1:0] credits;
  logic [CREDIT_W-1:0] last_payout;
  logic [CREDIT_W-1:0] pay_count;
  logic [CREDIT_W-1:0] payout;
  logic [BET_W-1:0]    bet_reg;
  logic [11:0]         digits_reg;
  win_class_t          win_class;
  win_class_t          class_now;
  logic [7:0]          mult;
  logic                bet_ok;
  logic                bet_reject;
  logic                armed, busy, result_valid;

  spin_payout_classifier u_classifier (
    .digits    (digits_reg),
    .win_class (class_now)
  );

  assign bet_ok = (bet_amount_nz()) && (CMP_W'(bus.bet_amount) <= CMP_W'(credits));

  function automatic logic bet_amount_nz();
    return bus.bet_amount != '0;
  endfunction

  always_comb begin
    mult = 8'd0;
    case (class_now)
      WIN_TRIPLE: mult = 8'(MULT_TRIPLE);
      WIN_RUN:    mult = 8'(MULT_RUN);
      WIN_PAIR:   mult = 8'(MULT_PAIR);
      default:    mult = 8'd0;
    endcase
  end

  // Product is formed wide and only then truncated to the balance width
  assign payout = CREDIT_W'(PROD_W'(bet_reg) * PROD_W'(mult));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state   = state;
    armed        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.bet_req && bet_ok) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        armed = 1'b1;
        if (bus.spin_valid) next_state = ST_EVAL;
      end
      ST_EVAL: begin
        busy       = 1'b1;
        next_state = (payout != '0) ? ST_PAY : ST_DONE;
      end
      ST_PAY: begin
        busy = 1'b1;
        if (pay_count == CREDIT_W'(1)) next_state = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        next_state   = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // PAY always runs payout cycles even once the balance has saturated
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      credits     <= CREDIT_W'(START_CREDITS);
      last_payout <= '0;
      pay_count   <= '0;
      bet_reg     <= '0;
      digits_reg  <= '0;
      win_class   <= WIN_NONE;
      bet_reject  <= 1'b0;
    end else begin
      bet_reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.bet_req) begin
            if (bet_ok) begin
              credits <= credits - CREDIT_W'(bus.bet_amount);
              bet_reg <= bus.bet_amount;
            end else begin
              bet_reject <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (bus.spin_valid) digits_reg <= bus.player_spin;
        end
        ST_EVAL: begin
          win_class   <= class_now;
          last_payout <= payout;
          pay_count   <= payout;
        end
        ST_PAY: begin
          pay_count <= pay_count - CREDIT_W'(1);
          if (credits != {CREDIT_W{1'b1}}) credits <= credits + CREDIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.credits      = credits;
  assign bus.last_payout  = last_payout;
  assign bus.win_class    = win_class;
  assign bus.armed        = armed;
  assign bus.busy         = busy;
  assign bus.result_valid = result_valid;
  assign bus.bet_reject   = bet_reject;
endmodule

// File: tb/tb_spin_payout.sv
// Bench for spin_payout: two instances (start 100 and 1020) checked against a
// behavioural model of balance, classification, payout and result timing.
module tb_spin_payout;
  localparam int CREDIT_W = 10;
  localparam int BET_W    = 4;
  localparam int CMAX     = (1 << CREDIT_W) - 1;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  spin_payout_if #(.CREDIT_W(CREDIT_W), .BET_W(BET_W)) bus0 ();
  spin_payout_if #(.CREDIT_W(CREDIT_W), .BET_W(BET_W)) bus1 ();

  spin_payout #(.CREDIT_W(CREDIT_W), .START_CREDITS(100), .BET_W(BET_W),
                .MULT_PAIR(2), .MULT_RUN(5), .MULT_TRIPLE(10)) dut0 (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus0)
  );

  spin_payout #(.CREDIT_W(CREDIT_W), .START_CREDITS(1020), .BET_W(BET_W),
                .MULT_PAIR(2), .MULT_RUN(5), .MULT_TRIPLE(10)) dut1 (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;
  int model_credits [2];
  int start_credits [2];
  int model_bet    = 0;

  int   obs_credits, obs_payout, obs_class;
  logic obs_armed, obs_busy, obs_rv, obs_reject;

  // Observation mux so the tasks can target whichever instance is selected
  always_comb begin
    if (sel == 1) begin
      obs_credits = int'(bus1.credits);
      obs_payout  = int'(bus1.last_payout);
      obs_class   = int'(bus1.win_class);
      obs_armed   = bus1.armed;
      obs_busy    = bus1.busy;
      obs_rv      = bus1.result_valid;
      obs_reject  = bus1.bet_reject;
    end else begin
      obs_credits = int'(bus0.credits);
      obs_payout  = int'(bus0.last_payout);
      obs_class   = int'(bus0.win_class);
      obs_armed   = bus0.armed;
      obs_busy    = bus0.busy;
      obs_rv      = bus0.result_valid;
      obs_reject  = bus0.bet_reject;
    end
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply_stimulus(input logic br, input int ba, input logic sv, input logic [11:0] ps);
    if (sel == 1) begin
      bus1.bet_req     = br;
      bus1.bet_amount  = BET_W'(ba);
      bus1.spin_valid  = sv;
      bus1.player_spin = ps;
    end else begin
      bus0.bet_req     = br;
      bus0.bet_amount  = BET_W'(ba);
      bus0.spin_valid  = sv;
      bus0.player_spin = ps;
    end
  endtask

  // Reference classification from the reel rules, using plain integer arithmetic
  function automatic int model_class(input logic [11:0] s);
    int d1, d2, d3, hits;
    d1 = int'(s[11:8]);
    d2 = int'(s[7:4]);
    d3 = int'(s[3:0]);
    hits = int'(d1 == d2) + int'(d2 == d3) + int'(d1 == d3);
    if (hits == 3) return 3;
    if (d2 - d1 == 1 && d3 - d2 == 1) return 2;
    if (hits == 1) return 1;
    return 0;
  endfunction

  function automatic int model_mult(input int cls);
    case (cls)
      3: return 10;
      2: return 5;
      1: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic do_bet(input int amount, output bit accepted);
    accepted = (amount > 0) && (amount <= model_credits[sel]);
    apply_stimulus(1'b1, amount, 1'b0, 12'h000);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    if (accepted) begin
      model_credits[sel] -= amount;
      model_bet = amount;
    end
    check_output("bet_credits", obs_credits, model_credits[sel]);
    check_output("bet_armed", int'(obs_armed), int'(accepted));
    check_output("bet_reject", int'(obs_reject), int'(!accepted));
    if (!accepted) begin
      tick();
      check_output("reject_pulse_end", int'(obs_reject), 0);
    end
  endtask

  task automatic do_spin(input logic [11:0] s);
    int cls, pay, base, rv_at, pulses, mid;
    cls  = model_class(s);
    pay  = model_bet * model_mult(cls);
    base = model_credits[sel];
    mid  = 2 + pay / 2;
    rv_at  = -1;
    pulses = 0;
    apply_stimulus(1'b0, 0, 1'b1, s);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    check_output("eval_busy", int'(obs_busy), 1);
    check_output("eval_armed", int'(obs_armed), 0);
    tick();
    check_output("win_class", obs_class, cls);
    check_output("last_payout", obs_payout, pay);
    for (int t = 2; t <= pay + 6; t++) begin
      if (obs_rv) begin
        pulses++;
        if (rv_at < 0) rv_at = t;
      end
      if (pay > 0 && t == mid)
        check_output("pay_credits_mid", obs_credits, (base + t - 2 > CMAX) ? CMAX : base + t - 2);
      if (t < pay + 6) tick();
    end
    model_credits[sel] = (base + pay > CMAX) ? CMAX : base + pay;
    check_output("result_latency", rv_at, pay + 2);
    check_output("result_pulses", pulses, 1);
    check_output("final_credits", obs_credits, model_credits[sel]);
    check_output("final_busy", int'(obs_busy), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_credits[0] = start_credits[0];
    model_credits[1] = start_credits[1];
  endtask

  initial begin
    bit ok;
    int seen_rv;
    start_credits[0] = 100;
    start_credits[1] = 1020;
    sel = 1;
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    sel = 0;
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);

    // Reset state
    do_reset();
    tick();
    tick();
    check_output("rst_credits", obs_credits, 100);
    check_output("rst_last_payout", obs_payout, 0);
    check_output("rst_win_class", obs_class, 0);
    check_output("rst_armed", int'(obs_armed), 0);
    check_output("rst_busy", int'(obs_busy), 0);
    check_output("rst_result_valid", int'(obs_rv), 0);
    resetn = 1'b1;
    tick();

    // Triple, run, pair and no-win spins
    $display("[TB] directed spins");
    do_bet(5, ok);
    do_spin(12'h777);
    do_bet(3, ok);
    do_spin(12'h345);
    do_bet(2, ok);
    do_spin(12'h3A3);
    do_bet(1, ok);
    do_spin(12'hEF0);
    do_bet(1, ok);
    do_spin(12'hEF0);

    // Reset while a payout is being credited
    do_bet(5, ok);
    apply_stimulus(1'b0, 0, 1'b1, 12'h777);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    for (int i = 0; i < 12; i++) tick();
    do_reset();
    check_output("midpay_rst_credits", obs_credits, 100);
    check_output("midpay_rst_busy", int'(obs_busy), 0);
    check_output("midpay_rst_payout", obs_payout, 0);
    tick();
    resetn = 1'b1;
    seen_rv = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (obs_rv || obs_busy) seen_rv++;
    end
    check_output("midpay_no_result", seen_rv, 0);
    check_output("midpay_credits_hold", obs_credits, 100);

    // Drain to 10 credits with losing spins, then the reject cases
    for (int i = 0; i < 6; i++) begin
      do_bet(15, ok);
      do_spin(12'hEF0);
    end
    check_output("drained_credits", obs_credits, 10);
    do_bet(15, ok);
    do_bet(0, ok);
    apply_stimulus(1'b0, 0, 1'b1, 12'h777);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    check_output("idle_spin_armed", int'(obs_armed), 0);
    check_output("idle_spin_busy", int'(obs_busy), 0);
    tick();
    check_output("idle_spin_credits", obs_credits, 10);

    // Bet and spin together in IDLE: bet taken, spin dropped; then bet while armed ignored
    apply_stimulus(1'b1, 3, 1'b1, 12'h777);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    model_credits[0] -= 3;
    model_bet = 3;
    tick();
    check_output("coincide_armed", int'(obs_armed), 1);
    check_output("coincide_busy", int'(obs_busy), 0);
    apply_stimulus(1'b1, 5, 1'b0, 12'h000);
    tick();
    apply_stimulus(1'b0, 0, 1'b0, 12'h000);
    check_output("armed_bet_credits", obs_credits, model_credits[0]);
    check_output("armed_bet_armed", int'(obs_armed), 1);
    do_spin(12'h9AB);

    // Saturation on the instance that starts at 1020
    $display("[TB] saturation");
    sel = 1;
    do_bet(1, ok);
    do_spin(12'hFFF);
    check_output("sat_credits", obs_credits, CMAX);
    sel = 0;

    // Randomized bets and spins
    $display("[TB] random spins");
    do_reset();
    tick();
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      int amt, mode, a, b;
      logic [11:0] s;
      amt  = int'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 15));
      b    = int'($urandom_range(0, 15));
      case (mode)
        1: s = {a[3:0], a[3:0], a[3:0]};
        2: begin
          a = int'($urandom_range(0, 13));
          s = {a[3:0], 4'(a + 1), 4'(a + 2)};
        end
        3: s = {a[3:0], b[3:0], a[3:0]};
        default: s = 12'($urandom);
      endcase
      do_bet(amt, ok);
      if (ok) do_spin(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
